ram_arbiter: RTL and testbench

Four-way arbiter that shares the single SDRAM controller port (`sram`) between the ioctl download/erase DMA, the tape buffer reader, the floppy buffer reader and the Z80 CPU. It replaces the combinational address/data muxing in front of the memory with a sequenced request/acknowledge scheme. The scheme has fixed priority, an anti-starvation guarantee for the CPU, and a per-requester read-data latch, so requesters no longer need to own the bus by mode. It sits between the requesters and `sram` in the `clk_sys` domain.

---
 rtl/ram_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: sequences dma, tape, fdd and cpu accesses onto the single sram port.
// Fixed priority dma > tape > fdd > cpu, with a starvation escape for the cpu.
module ram_arbiter #(
   parameter int AW     = 25,
   parameter int STARVE = 4
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_din,
   output logic          dma_ack,
   input  logic          tape_req,
   input  logic [AW-1:0] tape_addr,
   output logic          tape_ack,
   output logic [7:0]    tape_dout,
   input  logic          fdd_req,
   input  logic [AW-1:0] fdd_addr,
   output logic          fdd_ack,
   output logic [7:0]    fdd_dout,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_din,
   output logic          cpu_ack,
   output logic [7:0]    cpu_dout,
   output logic          cpu_wait,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_din,
   output logic          mem_rd,
   output logic          mem_we,
   input  logic [7:0]    mem_dout,
   input  logic          mem_ready
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_DONE
   } state_t;

   localparam logic [1:0] ID_DMA  = 2'd0;
   localparam logic [1:0] ID_TAPE = 2'd1;
   localparam logic [1:0] ID_FDD  = 2'd2;
   localparam logic [1:0] ID_CPU  = 2'd3;
   localparam logic [3:0] STARVE_L = 4'(STARVE);

   state_t        state;
   logic [1:0]    gnt_id;
   logic          gnt_we;
   logic [3:0]    starve_cnt;
   logic [3:0]    mask;
   logic [3:0]    req_v;
   logic          any_req;
   logic          cpu_first;
   logic [1:0]    win_id;
   logic [AW-1:0] win_addr;
   logic [7:0]    win_din;
   logic          win_we;

   // the requester acked last cycle sits out one arbitration round
   assign req_v     = {cpu_req, fdd_req, tape_req, dma_req} & ~mask;
   assign any_req   = |req_v;
   assign cpu_first = req_v[3] & (starve_cnt == STARVE_L);
   assign cpu_wait  = cpu_req & ~cpu_ack;

   always_comb begin
      win_id   = ID_CPU;
      win_addr = cpu_addr;
      win_din  = cpu_din;
      win_we   = cpu_we;
      if (req_v[0]) begin
         win_id   = ID_DMA;
         win_addr = dma_addr;
         win_din  = dma_din;
         win_we   = dma_we;
      end else if (cpu_first) begin
         win_id   = ID_CPU;
      end else if (req_v[1]) begin
         win_id   = ID_TAPE;
         win_addr = tape_addr;
         win_din  = 8'h00;
         win_we   = 1'b0;
      end else if (req_v[2]) begin
         win_id   = ID_FDD;
         win_addr = fdd_addr;
         win_din  = 8'h00;
         win_we   = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         gnt_id     <= ID_DMA;
         gnt_we     <= 1'b0;
         starve_cnt <= 4'd0;
         mask       <= 4'd0;
         mem_addr   <= '0;
         mem_din    <= 8'h00;
         mem_rd     <= 1'b0;
         mem_we     <= 1'b0;
         dma_ack    <= 1'b0;
         tape_ack   <= 1'b0;
         fdd_ack    <= 1'b0;
         cpu_ack    <= 1'b0;
         tape_dout  <= 8'h00;
         fdd_dout   <= 8'h00;
         cpu_dout   <= 8'h00;
      end else begin
         mem_rd   <= 1'b0;
         mem_we   <= 1'b0;
         dma_ack  <= 1'b0;
         tape_ack <= 1'b0;
         fdd_ack  <= 1'b0;
         cpu_ack  <= 1'b0;
         mask     <= 4'd0;
         if (!cpu_req) starve_cnt <= 4'd0;
         unique case (state)
            S_IDLE: begin
               if (mem_ready && any_req) begin
                  state    <= S_ISSUE;
                  gnt_id   <= win_id;
                  gnt_we   <= win_we;
                  mem_addr <= win_addr;
                  mem_din  <= win_din;
                  mem_we   <= win_we;
                  mem_rd   <= ~win_we;
                  if (win_id == ID_CPU)
                     starve_cnt <= 4'd0;
                  else if (cpu_req && starve_cnt != STARVE_L)
                     starve_cnt <= starve_cnt + 4'd1;
               end
            end
            S_ISSUE: state <= S_GAP;
            // controller needs a cycle before mem_ready reflects the command
            S_GAP:   state <= S_WAIT;
            S_WAIT: begin
               if (mem_ready) begin
                  state <= S_DONE;
                  unique case (gnt_id)
                     ID_DMA:  dma_ack  <= 1'b1;
                     ID_TAPE: tape_ack <= 1'b1;
                     ID_FDD:  fdd_ack  <= 1'b1;
                     default: cpu_ack  <= 1'b1;
                  endcase
                  if (!gnt_we) begin
                     unique case (gnt_id)
                        ID_TAPE: tape_dout <= mem_dout;
                        ID_FDD:  fdd_dout  <= mem_dout;
                        ID_CPU:  cpu_dout  <= mem_dout;
                        default: ;
                     endcase
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               mask  <= 4'b0001 << gnt_id;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors and corner sequences for ram_arbiter.
// Requester ids: 0 dma, 1 tape, 2 fdd, 3 cpu.
module tb_ram_arbiter;
   localparam int AW = 25;

   logic          clk_sys = 1'b0;
   logic          reset_n;
   logic          dma_req, dma_we, dma_ack;
   logic [AW-1:0] dma_addr;
   logic [7:0]    dma_din;
   logic          tape_req, tape_ack;
   logic [AW-1:0] tape_addr;
   logic [7:0]    tape_dout;
   logic          fdd_req, fdd_ack;
   logic [AW-1:0] fdd_addr;
   logic [7:0]    fdd_dout;
   logic          cpu_req, cpu_we, cpu_ack, cpu_wait;
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_din, cpu_dout;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din, mem_dout;
   logic          mem_rd, mem_we, mem_ready;

   typedef struct {
      int            id;
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    din;
      logic [7:0]    rdata;
      logic [7:0]    exp_dout;
   } vec_t;

   vec_t          vecs[8];
   int            n_vec = 0;
   int            n_err = 0;
   int            s_at, a_at, n_s, gi, cnt_s, cnt_a;
   logic          s_we;
   logic [AW-1:0] s_addr;
   logic [7:0]    s_din, sim_din;
   int            order[4];
   int            ack_n[4];
   int            seq[10];
   int            exp_seq[10] = '{1, 2, 1, 2, 3, 1, 2, 1, 2, 3};

   always #5 clk_sys = ~clk_sys;

   ram_arbiter #(.AW(AW), .STARVE(4)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_din(dma_din), .dma_ack(dma_ack),
      .tape_req(tape_req), .tape_addr(tape_addr),
      .tape_ack(tape_ack), .tape_dout(tape_dout),
      .fdd_req(fdd_req), .fdd_addr(fdd_addr),
      .fdd_ack(fdd_ack), .fdd_dout(fdd_dout),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .cpu_wait(cpu_wait),
      .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_rd(mem_rd), .mem_we(mem_we),
      .mem_dout(mem_dout), .mem_ready(mem_ready)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic set_req(input int id, input logic v);
      case (id)
         0: dma_req = v;
         1: tape_req = v;
         2: fdd_req = v;
         default: cpu_req = v;
      endcase
   endtask

   function automatic logic ack_of(input int id);
      case (id)
         0: return dma_ack;
         1: return tape_ack;
         2: return fdd_ack;
         default: return cpu_ack;
      endcase
   endfunction

   function automatic logic [7:0] dout_of(input int id);
      case (id)
         1: return tape_dout;
         2: return fdd_dout;
         3: return cpu_dout;
         default: return 8'h00;
      endcase
   endfunction

   // one transaction; cycle 1 is the sample right after the grant edge
   task automatic run_txn(input int id, input logic we,
                          input logic [AW-1:0] addr, input logic [7:0] din,
                          input logic [7:0] rdata);
      mem_dout = rdata;
      case (id)
         0: begin dma_we = we; dma_addr = addr; dma_din = din; end
         1: tape_addr = addr;
         2: fdd_addr = addr;
         default: begin cpu_we = we; cpu_addr = addr; cpu_din = din; end
      endcase
      set_req(id, 1'b1);
      s_at = -1; a_at = -1; n_s = 0;
      s_we = 1'b0; s_addr = '0; s_din = 8'h00;
      for (int c = 1; c <= 40 && a_at < 0; c++) begin
         tick();
         if (mem_rd || mem_we) begin
            n_s++;
            if (s_at < 0) begin
               s_at = c; s_we = mem_we; s_addr = mem_addr; s_din = mem_din;
            end
         end
         if (ack_of(id)) begin
            a_at = c;
            set_req(id, 1'b0);
         end
      end
   endtask

   task automatic wait_cpu_ack(output int at);
      at = -1;
      for (int c = 1; c <= 60 && at < 0; c++) begin
         tick();
         if (cpu_ack) at = c;
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_acks"}, {dma_ack, tape_ack, fdd_ack, cpu_ack}, 0);
      check({tag, "_strobes"}, {mem_rd, mem_we}, 0);
      check({tag, "_tape_dout"}, tape_dout, 0);
      check({tag, "_fdd_dout"}, fdd_dout, 0);
      check({tag, "_cpu_dout"}, cpu_dout, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_din"}, mem_din, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{3, 1'b0, 25'h0050010, 8'h00, 8'hA5, 8'hA5};
      vecs[1] = '{1, 1'b0, 25'h0000123, 8'h00, 8'h3C, 8'h3C};
      vecs[2] = '{2, 1'b0, 25'h01ABCDE, 8'h00, 8'h7E, 8'h7E};
      vecs[3] = '{3, 1'b1, 25'h000FFFF, 8'h5A, 8'hEE, 8'hA5};
      vecs[4] = '{0, 1'b1, 25'h1FFFFFF, 8'hC3, 8'h00, 8'h00};
      vecs[5] = '{0, 1'b0, 25'h0000000, 8'h00, 8'h11, 8'h00};
      vecs[6] = '{1, 1'b0, 25'h0000ABC, 8'h00, 8'h00, 8'h00};
      vecs[7] = '{3, 1'b0, 25'h1000000, 8'h00, 8'hFF, 8'hFF};

      reset_n = 1'b0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_din = 0;
      tape_req = 0; tape_addr = '0; fdd_req = 0; fdd_addr = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = 0;
      mem_dout = 0; mem_ready = 1'b1;
      repeat (3) tick();
      check_reset_outs("reset");
      check("reset_cpu_wait", cpu_wait, 0);
      reset_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i].id, vecs[i].we, vecs[i].addr,
                 vecs[i].din, vecs[i].rdata);
         check($sformatf("v%0d_ack_cycle", i), a_at, 4);
         check($sformatf("v%0d_strobe_cycle", i), s_at, 1);
         check($sformatf("v%0d_strobe_we", i), s_we, vecs[i].we);
         check($sformatf("v%0d_strobe_addr", i), s_addr, vecs[i].addr);
         check($sformatf("v%0d_addr_at_ack", i), mem_addr, vecs[i].addr);
         if (vecs[i].we)
            check($sformatf("v%0d_strobe_din", i), s_din, vecs[i].din);
         if (vecs[i].id != 0)
            check($sformatf("v%0d_dout", i), dout_of(vecs[i].id),
                  vecs[i].exp_dout);
         mem_dout = 8'hDB;
         repeat (2) begin
            tick();
            if (mem_rd || mem_we) n_s++;
         end
         check($sformatf("v%0d_strobe_count", i), n_s, 1);
         if (vecs[i].id != 0)
            check($sformatf("v%0d_dout_hold", i), dout_of(vecs[i].id),
                  vecs[i].exp_dout);
      end

      dma_we = 1; dma_addr = 25'h10; dma_din = 8'h3C;
      tape_addr = 25'h20; fdd_addr = 25'h30;
      cpu_addr = 25'h40; cpu_we = 0; mem_dout = 8'h99;
      dma_req = 1; tape_req = 1; fdd_req = 1; cpu_req = 1;
      gi = 0; sim_din = 0;
      for (int i = 0; i < 4; i++) ack_n[i] = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (mem_rd || mem_we) begin
            if (gi < 4) order[gi] = int'(mem_addr[7:4]);
            if (mem_we) sim_din = mem_din;
            gi++;
         end
         if (dma_ack)  begin ack_n[0]++; dma_req = 0; end
         if (tape_ack) begin ack_n[1]++; tape_req = 0; end
         if (fdd_ack)  begin ack_n[2]++; fdd_req = 0; end
         if (cpu_ack)  begin ack_n[3]++; cpu_req = 0; end
      end
      check("sim_grants", gi, 4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sim_order%0d", i), order[i], i + 1);
         check($sformatf("sim_acks%0d", i), ack_n[i], 1);
      end
      check("sim_dma_din", sim_din, 8'h3C);
      check("sim_tape_dout", tape_dout, 8'h99);
      check("sim_fdd_dout", fdd_dout, 8'h99);
      check("sim_cpu_dout", cpu_dout, 8'h99);

      tape_addr = 25'h100; fdd_addr = 25'h200; cpu_addr = 25'h300;
      cpu_we = 0; mem_dout = 8'h00;
      tape_req = 1; fdd_req = 1; cpu_req = 1;
      gi = 0;
      for (int c = 0; c < 120 && gi < 10; c++) begin
         tick();
         if (mem_rd || mem_we) begin
            seq[gi] = int'(mem_addr[9:8]);
            gi++;
         end
         cpu_req = cpu_ack ? 1'b0 : 1'b1;
      end
      tape_req = 0; fdd_req = 0; cpu_req = 0;
      check("starve_grants", gi, 10);
      for (int i = 0; i < 10; i++)
         check($sformatf("starve_seq%0d", i), seq[i], exp_seq[i]);
      repeat (8) tick();

      cpu_addr = 25'h0ABCD; cpu_we = 0; mem_dout = 8'h42; cpu_req = 1;
      tick();
      check("slow_strobe", mem_rd, 1);
      mem_ready = 0;
      cnt_s = 0; cnt_a = 0;
      repeat (20) begin
         tick();
         if (mem_rd || mem_we) cnt_s++;
         if (cpu_ack) cnt_a++;
      end
      check("slow_extra_strobes", cnt_s, 0);
      check("slow_early_ack", cnt_a, 0);
      check("slow_cpu_wait", cpu_wait, 1);
      mem_ready = 1;
      tick();
      check("slow_ack", cpu_ack, 1);
      check("slow_dout", cpu_dout, 8'h42);
      check("slow_wait_at_ack", cpu_wait, 0);
      cpu_req = 0;
      repeat (3) tick();

      cpu_addr = 25'h777; mem_dout = 8'h5C; cpu_req = 1;
      wait_cpu_ack(a_at);
      check("hold1_ack", a_at, 4);
      cnt_s = 0;
      repeat (2) begin
         tick();
         if (mem_rd || mem_we) cnt_s++;
      end
      cpu_req = 0;
      repeat (10) begin
         tick();
         if (mem_rd || mem_we) cnt_s++;
      end
      check("hold1_strobes", cnt_s, 0);
      check("hold1_dout", cpu_dout, 8'h5C);

      cpu_req = 1;
      wait_cpu_ack(a_at);
      check("hold2_ack", a_at, 4);
      cnt_s = 0; cnt_a = 0;
      repeat (3) begin
         tick();
         if (mem_rd || mem_we) cnt_s++;
      end
      cpu_req = 0;
      repeat (12) begin
         tick();
         if (mem_rd || mem_we) cnt_s++;
         if (cpu_ack) cnt_a++;
      end
      check("hold2_strobes", cnt_s, 1);
      check("hold2_acks", cnt_a, 1);

      fdd_addr = 25'h0ABC; mem_dout = 8'h66; fdd_req = 1;
      tick();
      check("rst_fdd_strobe", mem_rd, 1);
      mem_ready = 0;
      repeat (4) tick();
      #2 reset_n = 0;
      #1;
      check_reset_outs("arst");
      cnt_a = 0;
      mem_ready = 1;
      repeat (3) begin
         tick();
         if (fdd_ack) cnt_a++;
      end
      check("arst_no_fdd_ack", cnt_a, 0);
      reset_n = 1;
      run_txn(2, 1'b0, 25'h0ABC, 8'h00, 8'h66);
      check("arst_after_ack", a_at, 4);
      check("arst_after_strobe", s_at, 1);
      check("arst_after_dout", fdd_dout, 8'h66);
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
